// File: rtl/fpu_operand_unpack.sv
// Operand unpack/classify front end for the single-precision add/sub path, with a 2-entry skid buffer on the output.
// Optional macro FPU_OPERAND_FCLASS_EN adds RISC-V FCLASS one-hot outputs for both operands.
module fpu_operand_unpack #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 23
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+SIG_W:0]   operand_a_i,
    input  logic [EXP_W+SIG_W:0]   operand_b_i,
    input  logic                   sub_op_i,
    input  logic [2:0]             rm_field_i,
    input  logic [2:0]             frm_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   sign_a_o,
    output logic                   sign_b_o,
    output logic [EXP_W-1:0]       exp_a_o,
    output logic [EXP_W-1:0]       exp_b_o,
    output logic [SIG_W-1:0]       sig_a_o,
    output logic [SIG_W-1:0]       sig_b_o,
    output logic [SIG_W:0]         mant_a_o,
    output logic [SIG_W:0]         mant_b_o,
    output logic [EXP_W-1:0]       exp_eff_a_o,
    output logic [EXP_W-1:0]       exp_eff_b_o,
    output logic                   is_zero_a_o,
    output logic                   is_zero_b_o,
    output logic                   is_inf_a_o,
    output logic                   is_inf_b_o,
    output logic                   is_nan_a_o,
    output logic                   is_nan_b_o,
    output logic                   is_subnorm_a_o,
    output logic                   is_subnorm_b_o,
    output logic                   is_signaling_o,
    output logic                   sub_op_o,
    output logic [2:0]             rounding_mode_o,
`ifdef FPU_OPERAND_FCLASS_EN
    output logic [9:0]             fclass_a_o,
    output logic [9:0]             fclass_b_o,
`endif
    output logic                   illegal_rm_o
);

    localparam int OP_W = 1 + EXP_W + SIG_W;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic [SIG_W:0]   mant;
        logic [EXP_W-1:0] exp_eff;
        logic             zero;
        logic             inf;
        logic             nan;
        logic             subnorm;
`ifdef FPU_OPERAND_FCLASS_EN
        logic [9:0]       fclass;
`endif
    } opnd_t;

    typedef struct packed {
        opnd_t      a;
        opnd_t      b;
        logic       signaling;
        logic       sub_op;
        logic [2:0] rm;
        logic       illegal;
    } payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

    function automatic logic is_snan(input logic [OP_W-1:0] op);
        return (&op[OP_W-2:SIG_W]) && (op[SIG_W-1:0] != '0) && !op[SIG_W-1];
    endfunction

    function automatic opnd_t unpack_operand(input logic [OP_W-1:0] op);
        opnd_t o;
        logic  exp_zero;
        logic  exp_ones;
        logic  sig_zero;
        o        = '0;
        o.sign   = op[OP_W-1];
        o.exp    = op[OP_W-2:SIG_W];
        o.sig    = op[SIG_W-1:0];
        exp_zero = (o.exp == '0);
        exp_ones = &o.exp;
        sig_zero = (o.sig == '0);
        o.mant    = {!exp_zero, o.sig};
        o.exp_eff = exp_zero ? EXP_W'(1) : o.exp;
        o.zero    = exp_zero && sig_zero;
        o.inf     = exp_ones && sig_zero;
        o.nan     = exp_ones && !sig_zero;
        o.subnorm = exp_zero && !sig_zero;
`ifdef FPU_OPERAND_FCLASS_EN
        o.fclass[0] = o.sign && o.inf;
        o.fclass[1] = o.sign && !exp_zero && !exp_ones;
        o.fclass[2] = o.sign && o.subnorm;
        o.fclass[3] = o.sign && o.zero;
        o.fclass[4] = !o.sign && o.zero;
        o.fclass[5] = !o.sign && o.subnorm;
        o.fclass[6] = !o.sign && !exp_zero && !exp_ones;
        o.fclass[7] = !o.sign && o.inf;
        o.fclass[8] = o.nan && !o.sig[SIG_W-1];
        o.fclass[9] = o.nan && o.sig[SIG_W-1];
`endif
        return o;
    endfunction

    // Static rm field 111 means "use the dynamic mode from fcsr".
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm_field, input logic [2:0] frm);
        return (rm_field == 3'b111) ? frm : rm_field;
    endfunction

    function automatic logic rm_is_illegal(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

    payload_t pay_p0;
    payload_t main_p1;
    payload_t skid_p1;
    state_t   state_q;
    state_t   state_d;
    logic     push;
    logic     pop;
    logic     ld_main_in;
    logic     ld_main_skid;
    logic     ld_skid_in;

    always_comb begin
        pay_p0           = '0;
        pay_p0.a         = unpack_operand(operand_a_i);
        pay_p0.b         = unpack_operand(operand_b_i);
        pay_p0.signaling = is_snan(operand_a_i) || is_snan(operand_b_i);
        pay_p0.sub_op    = sub_op_i;
        pay_p0.rm        = resolve_rm(rm_field_i, frm_i);
        pay_p0.illegal   = rm_is_illegal(pay_p0.rm);
    end

    // in_ready/out_valid are pure decodes of the state flops, so no input reaches an output.
    assign in_ready_o  = (state_q != TWO);
    assign out_valid_o = (state_q != EMPTY);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE:     if (push && !pop) state_d = TWO;
                     else if (!push && pop) state_d = EMPTY;
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        case (state_q)
            EMPTY:   ld_main_in = push;
            ONE: begin
                ld_main_in = push && pop;
                ld_skid_in = push && !pop;
            end
            TWO:     ld_main_skid = pop;
            default: ;
        endcase
    end

    // Stage p0 -> p1: main holds the presented result, skid absorbs one extra under backpressure.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            if (ld_main_skid)    main_p1 <= skid_p1;
            else if (ld_main_in) main_p1 <= pay_p0;
            if (ld_skid_in)      skid_p1 <= pay_p0;
        end
    end

    assign sign_a_o        = main_p1.a.sign;
    assign sign_b_o        = main_p1.b.sign;
    assign exp_a_o         = main_p1.a.exp;
    assign exp_b_o         = main_p1.b.exp;
    assign sig_a_o         = main_p1.a.sig;
    assign sig_b_o         = main_p1.b.sig;
    assign mant_a_o        = main_p1.a.mant;
    assign mant_b_o        = main_p1.b.mant;
    assign exp_eff_a_o     = main_p1.a.exp_eff;
    assign exp_eff_b_o     = main_p1.b.exp_eff;
    assign is_zero_a_o     = main_p1.a.zero;
    assign is_zero_b_o     = main_p1.b.zero;
    assign is_inf_a_o      = main_p1.a.inf;
    assign is_inf_b_o      = main_p1.b.inf;
    assign is_nan_a_o      = main_p1.a.nan;
    assign is_nan_b_o      = main_p1.b.nan;
    assign is_subnorm_a_o  = main_p1.a.subnorm;
    assign is_subnorm_b_o  = main_p1.b.subnorm;
    assign is_signaling_o  = main_p1.signaling;
    assign sub_op_o        = main_p1.sub_op;
    assign rounding_mode_o = main_p1.rm;
    assign illegal_rm_o    = main_p1.illegal;
`ifdef FPU_OPERAND_FCLASS_EN
    assign fclass_a_o      = main_p1.a.fclass;
    assign fclass_b_o      = main_p1.b.fclass;
`endif

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Directed-vector bench for fpu_operand_unpack; FCLASS checks follow FPU_OPERAND_FCLASS_EN.
module tb_fpu_operand_unpack;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        sub_op_i;
    logic [2:0]  rm_field_i;
    logic [2:0]  frm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        sign_a_o, sign_b_o;
    logic [7:0]  exp_a_o, exp_b_o;
    logic [22:0] sig_a_o, sig_b_o;
    logic [23:0] mant_a_o, mant_b_o;
    logic [7:0]  exp_eff_a_o, exp_eff_b_o;
    logic        is_zero_a_o, is_zero_b_o, is_inf_a_o, is_inf_b_o;
    logic        is_nan_a_o, is_nan_b_o, is_subnorm_a_o, is_subnorm_b_o;
    logic        is_signaling_o;
    logic        sub_op_o;
    logic [2:0]  rounding_mode_o;
    logic        illegal_rm_o;
`ifdef FPU_OPERAND_FCLASS_EN
    logic [9:0]  fclass_a_o, fclass_b_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    fpu_operand_unpack #(.EXP_W(8), .SIG_W(23)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .sub_op_i(sub_op_i), .rm_field_i(rm_field_i), .frm_i(frm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .sign_a_o(sign_a_o), .sign_b_o(sign_b_o),
        .exp_a_o(exp_a_o), .exp_b_o(exp_b_o),
        .sig_a_o(sig_a_o), .sig_b_o(sig_b_o),
        .mant_a_o(mant_a_o), .mant_b_o(mant_b_o),
        .exp_eff_a_o(exp_eff_a_o), .exp_eff_b_o(exp_eff_b_o),
        .is_zero_a_o(is_zero_a_o), .is_zero_b_o(is_zero_b_o),
        .is_inf_a_o(is_inf_a_o), .is_inf_b_o(is_inf_b_o),
        .is_nan_a_o(is_nan_a_o), .is_nan_b_o(is_nan_b_o),
        .is_subnorm_a_o(is_subnorm_a_o), .is_subnorm_b_o(is_subnorm_b_o),
        .is_signaling_o(is_signaling_o), .sub_op_o(sub_op_o),
        .rounding_mode_o(rounding_mode_o),
`ifdef FPU_OPERAND_FCLASS_EN
        .fclass_a_o(fclass_a_o), .fclass_b_o(fclass_b_o),
`endif
        .illegal_rm_o(illegal_rm_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One-cycle request; results are in the main register on return.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [2:0] rm, input logic [2:0] frm);
        operand_a_i = a;
        operand_b_i = b;
        sub_op_i    = sub;
        rm_field_i  = rm;
        frm_i       = frm;
        in_valid_i  = 1'b1;
        tick();
        in_valid_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i     = 1'b0;
        in_valid_i  = 1'b1;
        operand_a_i = 32'h3F80_0000;
        operand_b_i = 32'hFF80_0000;
        sub_op_i    = 1'b0;
        rm_field_i  = 3'b001;
        frm_i       = 3'b000;
        out_ready_i = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_exp_a", exp_a_o, 0);
        chk("rst_mant_a", mant_a_o, 0);
        chk("rst_sign_b", sign_b_o, 0);
        chk("rst_inf_b", is_inf_b_o, 0);
        chk("rst_rm", rounding_mode_o, 0);

        reset_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        chk("first_valid", out_valid_o, 1);
        chk("first_exp_a", exp_a_o, 127);
        chk("first_sign_b", sign_b_o, 1);
        chk("first_inf_b", is_inf_b_o, 1);
        chk("first_rm", rounding_mode_o, 3'b001);
        tick();
        chk("drain_valid", out_valid_o, 0);

        send(32'h0000_0000, 32'h7F80_0000, 1'b1, 3'b000, 3'b000);
        chk("zi_zero_a", is_zero_a_o, 1);
        chk("zi_inf_b", is_inf_b_o, 1);
        chk("zi_nan_b", is_nan_b_o, 0);
        chk("zi_sign_b", sign_b_o, 0);
        chk("zi_sub", sub_op_o, 1);
        chk("zi_rm", rounding_mode_o, 3'b000);
        chk("zi_ill", illegal_rm_o, 0);

        send(32'h7FA0_0000, 32'h7FC0_0000, 1'b0, 3'b000, 3'b000);
        chk("nan_a", is_nan_a_o, 1);
        chk("nan_b", is_nan_b_o, 1);
        chk("nan_inf_a", is_inf_a_o, 0);
        chk("nan_sig", is_signaling_o, 1);
`ifdef FPU_OPERAND_FCLASS_EN
        chk("fclass_a_snan", fclass_a_o, 10'h100);
        chk("fclass_b_qnan", fclass_b_o, 10'h200);
`endif
        send(32'h7FC0_0000, 32'h7FC0_0001, 1'b0, 3'b000, 3'b000);
        chk("qq_sig", is_signaling_o, 0);
        send(32'h7FC0_0000, 32'hFF80_0001, 1'b0, 3'b000, 3'b000);
        chk("qs_sig", is_signaling_o, 1);
        chk("qs_sign_b", sign_b_o, 1);

        send(32'h0000_0001, 32'h3F80_0000, 1'b0, 3'b000, 3'b000);
        chk("sub_subnorm_a", is_subnorm_a_o, 1);
        chk("sub_zero_a", is_zero_a_o, 0);
        chk("sub_mant_a", mant_a_o, 24'h000001);
        chk("sub_exp_eff_a", exp_eff_a_o, 1);
        chk("sub_exp_a", exp_a_o, 0);
        chk("sub_sig_a", sig_a_o, 1);
        chk("one_mant_b", mant_b_o, 24'h800000);
        chk("one_exp_eff_b", exp_eff_b_o, 127);
        chk("one_subnorm_b", is_subnorm_b_o, 0);
`ifdef FPU_OPERAND_FCLASS_EN
        chk("fclass_a_psub", fclass_a_o, 10'h020);
        chk("fclass_b_pnorm", fclass_b_o, 10'h040);
`endif
        send(32'h8000_0000, 32'hC000_0000, 1'b0, 3'b000, 3'b000);
        chk("nz_zero_a", is_zero_a_o, 1);
        chk("nz_sign_a", sign_a_o, 1);
        chk("nz_mant_b", mant_b_o, 24'h800000);
        chk("nz_exp_b", exp_b_o, 128);
`ifdef FPU_OPERAND_FCLASS_EN
        chk("fclass_a_nzero", fclass_a_o, 10'h008);
        chk("fclass_b_nnorm", fclass_b_o, 10'h002);
`endif

        send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b111, 3'b010);
        chk("dyn_rm", rounding_mode_o, 3'b010);
        chk("dyn_ill", illegal_rm_o, 0);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b101, 3'b010);
        chk("st101_rm", rounding_mode_o, 3'b101);
        chk("st101_ill", illegal_rm_o, 1);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b111, 3'b110);
        chk("dyn110_rm", rounding_mode_o, 3'b110);
        chk("dyn110_ill", illegal_rm_o, 1);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b100, 3'b111);
        chk("st100_rm", rounding_mode_o, 3'b100);
        chk("st100_ill", illegal_rm_o, 0);
        tick();
        chk("idle_valid", out_valid_o, 0);

        // Backpressure: R1 exp 127, R2 exp 128, R3 exp 129.
        out_ready_i = 1'b0;
        operand_a_i = 32'h3F80_0000;
        operand_b_i = 32'h0000_0000;
        sub_op_i    = 1'b1;
        rm_field_i  = 3'b000;
        in_valid_i  = 1'b1;
        chk("bp_ready0", in_ready_o, 1);
        tick();
        chk("bp_valid1", out_valid_o, 1);
        chk("bp_ready1", in_ready_o, 1);
        chk("bp_r1_exp", exp_a_o, 127);
        operand_a_i = 32'h4000_0000;
        sub_op_i    = 1'b0;
        tick();
        chk("bp_ready_full", in_ready_o, 0);
        chk("bp_hold_exp", exp_a_o, 127);
        operand_a_i = 32'h4080_0000;
        sub_op_i    = 1'b1;
        tick();
        chk("bp_ready_full2", in_ready_o, 0);
        chk("bp_hold_exp2", exp_a_o, 127);
        chk("bp_hold_sub", sub_op_o, 1);
        out_ready_i = 1'b1;
        tick();
        chk("bp_r2_valid", out_valid_o, 1);
        chk("bp_r2_exp", exp_a_o, 128);
        chk("bp_r2_sub", sub_op_o, 0);
        chk("bp_r2_ready", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
        chk("bp_r3_valid", out_valid_o, 1);
        chk("bp_r3_exp", exp_a_o, 129);
        chk("bp_r3_sub", sub_op_o, 1);
        tick();
        chk("bp_drained", out_valid_o, 0);

        // Reset while both entries are full.
        out_ready_i = 1'b0;
        send(32'h3F80_0000, 32'h0, 1'b0, 3'b000, 3'b000);
        send(32'h4000_0000, 32'h0, 1'b0, 3'b000, 3'b000);
        chk("mid_full", in_ready_o, 0);
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        chk("mid_rst_valid", out_valid_o, 0);
        chk("mid_rst_ready", in_ready_o, 1);
        chk("mid_rst_exp", exp_a_o, 0);
        out_ready_i = 1'b1;
        tick();
        chk("mid_rst_no_ghost", out_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_operand_unpack.md
Name: fpu_operand_unpack

Overview:
- Front-end stage of the single-precision add/sub datapath; the producer side of the special-case interface consumed by the fast-result logic.
- Accepts two packed IEEE-754 operands plus an op/rounding request over a valid/ready handshake.
- Splits each operand into fields, classifies it, and resolves the rounding mode.
- Presents the registered results downstream through a 2-entry elastic (skid) buffer, giving full throughput with registered outputs.

Parameters:
- EXP_W, 8, exponent field width
- SIG_W, 23, stored significand width; packed operand width is 1+EXP_W+SIG_W

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-low reset
- in_valid_i  input  1  request valid
- in_ready_o  output  1  block can accept a request
- operand_a_i  input  1+EXP_W+SIG_W  packed operand A
- operand_b_i  input  1+EXP_W+SIG_W  packed operand B
- sub_op_i  input  1  1 = A-B, 0 = A+B
- rm_field_i  input  3  instruction rm field
- frm_i  input  3  dynamic rounding mode from fcsr
- out_valid_o  output  1  result valid
- out_ready_i  input  1  downstream accepts
- sign_a_o, sign_b_o  output  1  sign bits; B is not inverted for sub
- exp_a_o, exp_b_o  output  EXP_W  raw exponents
- sig_a_o, sig_b_o  output  SIG_W  raw stored significands
- mant_a_o, mant_b_o  output  SIG_W+1  {hidden bit, sig}; hidden bit = (exp!=0)
- exp_eff_a_o, exp_eff_b_o  output  EXP_W  exp, or 1 when exp==0
- is_zero_a_o, is_zero_b_o, is_inf_a_o, is_inf_b_o, is_nan_a_o, is_nan_b_o  output  1  classification
- is_subnorm_a_o, is_subnorm_b_o  output  1  exp==0 and sig!=0
- is_signaling_o  output  1  A or B is a signalling NaN
- sub_op_o  output  1  registered sub_op_i
- rounding_mode_o  output  3  resolved rounding mode
- illegal_rm_o  output  1  resolved rm is 101/110/111

Behaviour:
- Reset (reset_i==0 at a clk_i edge): both buffer entries invalid; out_valid_o=0; in_ready_o=1; all data outputs 0. Reset mid-transfer drops both entries with no partial output.
- Classification per operand:
  - zero = exp==0 && sig==0
  - inf = exp==all-ones && sig==0
  - nan = exp==all-ones && sig!=0
  - sNaN = nan && sig[SIG_W-1]==0
  - is_signaling_o = sNaN_A | sNaN_B
  - At most one of zero/inf/nan/subnorm is set per operand.
- Rounding resolution: rm_field_i==3'b111 selects frm_i, otherwise rm_field_i. illegal_rm_o=1 when the resolved value is 101, 110 or 111. rounding_mode_o carries the resolved value unchanged.
- Transfers: input transfer occurs when in_valid_i&&in_ready_o; output transfer occurs when out_valid_o&&out_ready_i. Latency is 1 cycle: a request accepted at edge N is visible at out_valid_o after edge N.
- Buffer states, encoded by occupancy: EMPTY, ONE (main valid), TWO (main+skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept and no pop -> TWO; accept and pop -> ONE, main reloaded with new data; pop only -> EMPTY.
  - TWO: in_ready_o=0; pop -> ONE, skid moves to main.
- in_ready_o = !(state==TWO) and is a registered signal; it does not depend combinationally on out_ready_i.
- Output data comes only from the main register and is stable while out_valid_o&&!out_ready_i.
- Ordering is strict FIFO; no request is dropped or duplicated.
- All outputs are registered; no combinational path exists from any input to any output.

Optional Feature:
- Macro FPU_OPERAND_FCLASS_EN.
- Defined: adds outputs fclass_a_o and fclass_b_o [9:0], registered and buffered alongside the other outputs, in RISC-V FCLASS one-hot encoding:
  - bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0
  - bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf
  - bit8 sNaN, bit9 qNaN
  - Both outputs reset to 0.
- Undefined: the ports and their buffer storage do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset_i=0 with in_valid_i=1 -> out_valid_o=0, in_ready_o=1, all outputs 0. Release reset -> first request appears after 1 cycle.
- A=0x00000000, B=0x7F800000, sub_op_i=1, rm_field_i=000, out_ready_i=1 -> is_zero_a_o=1, is_inf_b_o=1, sub_op_o=1, rounding_mode_o=000, illegal_rm_o=0.
- A=0x7FA00000 (sNaN), B=0x7FC00000 (qNaN) -> is_nan_a_o=1, is_nan_b_o=1, is_signaling_o=1. With FPU_OPERAND_FCLASS_EN: fclass_a_o=0x100, fclass_b_o=0x200.
- A=0x00000001, B=0x3F800000 -> A: is_subnorm_a_o=1, mant_a_o=0x000001, exp_eff_a_o=1. B: mant_b_o=0x800000, exp_eff_b_o=127.
- rm_field_i=111, frm_i=010 -> rounding_mode_o=010, illegal_rm_o=0. Then rm_field_i=101 -> illegal_rm_o=1. Then rm_field_i=111, frm_i=110 -> illegal_rm_o=1.
- Backpressure: out_ready_i=0, three back-to-back requests -> first two accepted, in_ready_o=0 on the third. Raise out_ready_i -> results emerge in order 1, 2, 3 with one per cycle once streaming and no loss.
